// File: rtl/layer_seq_pkg.sv
// rtl/layer_seq_pkg.sv - shared state encoding and default sizing for the layer sequencer
package layer_seq_pkg;

    localparam int DEF_NUM_LAYERS = 4;
    localparam int DEF_TIMEOUT    = 1000000;
    localparam int DEF_CNT_W      = 24;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_GAP  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - saturating per-layer cycle watchdog with synchronous clear
module seq_watchdog
    import layer_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    // Reflects the count before this cycle's increment, so expiry lands TIMEOUT cycles after entry.
    assign expired = en && (count >= limit);

endmodule

// File: rtl/layer_seq_ctrl.sv
// rtl/layer_seq_ctrl.sv - sequences network layers one at a time with watchdog; LAYER_SEQ_PERF_EN adds per-layer cycle counters
module layer_seq_ctrl
    import layer_seq_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int IDX_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_finish,
    output logic [NUM_LAYERS-1:0] layer_en,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [IDX_W-1:0]      cur_layer,
    input  logic [IDX_W-1:0]      perf_sel,
    output logic [CNT_W-1:0]      perf_cnt
);

    seq_state_t       state;
    logic             start_ok;
    logic             fin_cur;
    logic             wd_clr;
    logic             wd_en;
    logic             wd_expired;
    logic [IDX_W-1:0] next_layer;

    assign start_ok   = (state == ST_IDLE) && start && !abort;
    // In RUN the enable vector is one-hot on cur_layer, so masking selects only its finish bit.
    assign fin_cur    = |(layer_finish & layer_en);
    assign wd_clr     = start_ok || ((state == ST_GAP) && !abort);
    assign wd_en      = (state == ST_RUN);
    assign next_layer = cur_layer + IDX_W'(1);

    seq_watchdog #(
        .CNT_W (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .limit   (CNT_W'(TIMEOUT - 1)),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            layer_en  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cur_layer <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state    <= ST_IDLE;
                layer_en <= '0;
                busy     <= 1'b0;
                error    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state     <= ST_RUN;
                            cur_layer <= '0;
                            layer_en  <= NUM_LAYERS'(1);
                            busy      <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (fin_cur) begin
                            layer_en <= '0;
                            if (cur_layer == IDX_W'(NUM_LAYERS - 1)) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= ST_GAP;
                            end
                        end else if (wd_expired) begin
                            state    <= ST_ERR;
                            layer_en <= '0;
                            error    <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                    ST_GAP: begin
                        state     <= ST_RUN;
                        cur_layer <= next_layer;
                        layer_en  <= NUM_LAYERS'(1) << next_layer;
                    end
                    ST_DONE: state <= ST_IDLE;
                    ST_ERR:  state <= ST_ERR;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef LAYER_SEQ_PERF_EN
    logic [CNT_W-1:0] perf_q [NUM_LAYERS];
    logic [CNT_W-1:0] perf_mux;

    always_comb begin
        perf_mux = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (perf_sel == IDX_W'(i)) begin
                perf_mux = perf_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                perf_q[i] <= '0;
            end
            perf_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (start_ok) begin
                    perf_q[i] <= '0;
                end else if (layer_en[i] && (perf_q[i] != '1)) begin
                    perf_q[i] <= perf_q[i] + CNT_W'(1);
                end
            end
            perf_cnt <= perf_mux;
        end
    end
`else
    logic unused_perf_sel;
    assign unused_perf_sel = ^perf_sel;
    assign perf_cnt        = '0;
`endif

endmodule
